panel_ctrl: RTL
===============

# panel_ctrl

Parametrised front-panel controller for the board top level. It takes the four raw push-buttons (up, left, right, confirm) and the slide switches, and debounces and edge-detects each button. It adds auto-repeat on left/right and runs the IDLE → SELECT → INPUT → RUN operator flow over a configurable number of modes. Its outputs feed the seven-segment printer (mode, state) and the LEDs/datapath (latched switch word).

## Interface
- DB_CYCLES, default 200000, consecutive stable synchronised samples needed to accept a level change (≥ 2).
- REPEAT_DELAY, default 25000000, hold cycles on left/right before the first auto-repeat pulse.
- REPEAT_RATE, default 5000000, cycles between subsequent repeat pulses (≥ 1).
- N_MODES, default 8, number of selectable modes (2..16).
- IN_W, default 8, switch/data width.
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- btn_i  in  4  raw buttons, asynchronous; [0]=up, [1]=left, [2]=right, [3]=confirm.
- switch  in  IN_W  raw switches, treated as quasi-static.
- state  out  2  0=IDLE, 1=SELECT, 2=INPUT, 3=RUN.
- mode  out  4  selected mode, 0..N_MODES-1.
- data_o  out  IN_W  switch word latched on the INPUT confirm.
- data_valid  out  1  one-cycle pulse when data_o updates.
- btn_press  out  4  one-cycle press pulses (debounced, repeat included), for other consumers.

## Operation
- Per button: 2-FF synchroniser, then a stability counter. A level change is accepted only after DB_CYCLES consecutive synchronised samples that differ from the current debounced level. Any sample equal to the current level clears the counter.
- Press pulse fires on a debounced 0→1 transition; release produces nothing.
- Left/right auto-repeat:
  - The hold counter starts at the press pulse.
  - Extra pulses fire at REPEAT_DELAY, then every REPEAT_RATE cycles, while the debounced level stays 1.
  - Release clears the counter.
  - Up/confirm never repeat.
- Event arbitration per cycle: up > confirm > left/right. Left and right pulsing in the same cycle cancel each other.
- FSM:
  - IDLE: confirm → SELECT.
  - SELECT: left → mode−1, wrapping 0 → N_MODES−1. Right → mode+1, wrapping N_MODES−1 → 0. Confirm → INPUT. Up → IDLE, mode kept.
  - INPUT: confirm → data_o ← switch, data_valid = 1, go to RUN. Up → SELECT. Left/right ignored.
  - RUN: confirm → IDLE. Up → SELECT. data_o held.
- Mode arithmetic is modulo N_MODES, never exceeding N_MODES−1. Unused upper mode bits are 0.
- switch is passed through a 2-FF synchroniser before latching.

## Timing
- Reset values: state=0, mode=0, data_o=0, data_valid=0, btn_press=0. All synchroniser, debounce and repeat counters clear; debounced levels = 0.
- A button held high at reset release registers as a press after full debounce.
- Raw edge at cycle t0, held stable: debounced level changes at t0+2+DB_CYCLES; the btn_press pulse is in cycle t0+3+DB_CYCLES.
- FSM, mode, data_o and data_valid update on the clock edge after the btn_press pulse. data_valid is high for exactly that one cycle.
- A glitch shorter than DB_CYCLES synchronised samples produces no pulse.
- rst mid-operation wins over every event in the same cycle.

## Structure
- Package panel_pkg:
  - state encodings ST_IDLE, ST_SELECT, ST_INPUT, ST_RUN;
  - button indices BTN_UP, BTN_LEFT, BTN_RIGHT, BTN_CONFIRM.
- Sub-module btn_debounce (synchroniser + stability counter + edge pulse + optional repeat, enabled by a REPEAT parameter), instantiated four times.
- The FSM and switch latch live in panel_ctrl.

## Test plan
Bench parameters: DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, N_MODES=5, IN_W=8.
- Reset, then confirm held 10 cycles → one btn_press[3] at cycle t0+7; state 0→1 next edge; mode=0.
- In SELECT, left pressed once → mode=4 (wrap). Right pressed twice → mode=1. Right held 40 cycles → initial pulse plus repeats at +20, +25, +30, +35, so mode advances 5 and returns to the same value.
- Confirm → INPUT; switch=0xA5; confirm → data_o=0xA5, data_valid high for 1 cycle, state=3. Then up → state=1, data_o still 0xA5.
- Confirm bouncing 0/1 every 2 cycles for 30 cycles, then low → no btn_press, no state change.
- Left and right raw edges in the same cycle → both pulse in the same cycle, mode unchanged. Up with confirm in the same cycle while in INPUT → state=1 (up wins).
- rst asserted one cycle in RUN with data_o=0x3C → next edge: state=0, mode=0, data_o=0, counters cleared; a subsequent glitch of 3 cycles → no press.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel controller: operator-flow states,
// button positions on the raw button bus, and a counter-width helper.
package panel_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_INPUT  = 2'd2,
      ST_RUN    = 2'd3
   } state_e;

   localparam int BTN_UP      = 0;
   localparam int BTN_LEFT    = 1;
   localparam int BTN_RIGHT   = 2;
   localparam int BTN_CONFIRM = 3;
   localparam int N_BTN       = 4;

   // Bits needed to hold values 0..max_val, never less than one.
   function automatic int cnt_width(input int max_val);
      int w;
      w = $clog2(max_val + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-FF synchroniser, stability-counter debounce, press pulse
// on the debounced rising edge, and optional hold-to-repeat pulses.
module btn_debounce
   import panel_pkg::*;
#(
   parameter int DB_CYCLES    = 200000,
   parameter bit REPEAT       = 1'b0,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_i,
   output logic press_o
);

   localparam int DB_W   = cnt_width(DB_CYCLES);
   localparam int RP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RP_W   = cnt_width(RP_MAX);

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            level_q, level_d;
   logic            level_prev_q;
   logic            press_q, press_d;
   logic            rise;
   logic            rep_fire;

   // The counter only runs while the synchronised input disagrees with the
   // accepted level; any agreeing sample restarts the qualification window.
   always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      if (sync2_q != level_q) begin
         if (db_cnt_q == DB_LAST) begin
            level_d = sync2_q;
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end
      end
   end

   assign rise    = level_q & ~level_prev_q;
   assign press_d = rise | rep_fire;

   generate
      if (REPEAT) begin : g_rep
         localparam logic [RP_W-1:0] DELAY_LAST = RP_W'(REPEAT_DELAY - 1);
         localparam logic [RP_W-1:0] RATE_LAST  = RP_W'(REPEAT_RATE - 1);

         logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
         logic            rep_first_q, rep_first_d;

         // Counts cycles since the last pulse; the first interval is the
         // long delay, later ones the repeat rate.
         always_comb begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
            rep_fire    = 1'b0;
            if (level_q && !rise) begin
               rep_first_d = rep_first_q;
               if (rep_cnt_q == (rep_first_q ? DELAY_LAST : RATE_LAST)) begin
                  rep_fire    = 1'b1;
                  rep_first_d = 1'b0;
               end else begin
                  rep_cnt_d = rep_cnt_q + 1'b1;
               end
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               rep_cnt_q   <= '0;
               rep_first_q <= 1'b1;
            end else begin
               rep_cnt_q   <= rep_cnt_d;
               rep_first_q <= rep_first_d;
            end
         end
      end else begin : g_norep
         assign rep_fire = 1'b0;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         db_cnt_q     <= '0;
         level_q      <= 1'b0;
         level_prev_q <= 1'b0;
         press_q      <= 1'b0;
      end else begin
         sync1_q      <= btn_i;
         sync2_q      <= sync1_q;
         db_cnt_q     <= db_cnt_d;
         level_q      <= level_d;
         level_prev_q <= level_q;
         press_q      <= press_d;
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/panel_ctrl.sv
// Front-panel controller: four debounced buttons drive the IDLE/SELECT/INPUT/RUN
// operator flow, mode selection and the latched switch word.
module panel_ctrl
   import panel_pkg::*;
#(
   parameter int DB_CYCLES    = 200000,
   parameter int REPEAT_DELAY = 25000000,
   parameter int REPEAT_RATE  = 5000000,
   parameter int N_MODES      = 8,
   parameter int IN_W         = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [3:0]      btn_i,
   input  logic [IN_W-1:0] switch,
   output logic [1:0]      state,
   output logic [3:0]      mode,
   output logic [IN_W-1:0] data_o,
   output logic            data_valid,
   output logic [3:0]      btn_press
);

   localparam logic [3:0] MODE_MAX = 4'(N_MODES - 1);

   logic [N_BTN-1:0] press;

   generate
      for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
         btn_debounce #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT       (1'(gi == BTN_LEFT || gi == BTN_RIGHT)),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
         ) u_db (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (btn_i[gi]),
            .press_o (press[gi])
         );
      end
   endgenerate

   logic [IN_W-1:0] sw_s1_q, sw_s2_q;
   state_e          state_q, state_d;
   logic [3:0]      mode_q, mode_d;
   logic [IN_W-1:0] data_q, data_d;
   logic            valid_q, valid_d;

   logic ev_up, ev_confirm, ev_left, ev_right;

   // Up outranks confirm, which outranks left/right; opposing arrows cancel.
   assign ev_up      = press[BTN_UP];
   assign ev_confirm = press[BTN_CONFIRM] & ~ev_up;
   assign ev_left    = press[BTN_LEFT]  & ~press[BTN_RIGHT] & ~ev_up & ~ev_confirm;
   assign ev_right   = press[BTN_RIGHT] & ~press[BTN_LEFT]  & ~ev_up & ~ev_confirm;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      data_d  = data_q;
      valid_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (ev_confirm) state_d = ST_SELECT;
         end
         ST_SELECT: begin
            if (ev_up) begin
               state_d = ST_IDLE;
            end else if (ev_confirm) begin
               state_d = ST_INPUT;
            end else if (ev_left) begin
               mode_d = (mode_q == 4'd0) ? MODE_MAX : mode_q - 4'd1;
            end else if (ev_right) begin
               mode_d = (mode_q >= MODE_MAX) ? 4'd0 : mode_q + 4'd1;
            end
         end
         ST_INPUT: begin
            if (ev_up) begin
               state_d = ST_SELECT;
            end else if (ev_confirm) begin
               state_d = ST_RUN;
               data_d  = sw_s2_q;
               valid_d = 1'b1;
            end
         end
         ST_RUN: begin
            if (ev_up) begin
               state_d = ST_SELECT;
            end else if (ev_confirm) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sw_s1_q <= '0;
         sw_s2_q <= '0;
         state_q <= ST_IDLE;
         mode_q  <= 4'd0;
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         sw_s1_q <= switch;
         sw_s2_q <= sw_s1_q;
         state_q <= state_d;
         mode_q  <= mode_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign state      = state_q;
   assign mode       = mode_q;
   assign data_o     = data_q;
   assign data_valid = valid_q;
   assign btn_press  = press;

endmodule
